// File: rtl/apb_slave_regbank_pkg.sv
// bridge_utils -- shared types for the APB slave register bank.
//   apb_slv_state_t : transfer FSM states (IDLE, WAIT, READY)
//   WAIT_CNT_W      : width of the wait-state counter (WAIT_CYCLES 0..15)
// Optional feature macro used by this slice: APB_SLV_PSTRB_EN.
package bridge_utils;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_t;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slave_regbank_if.sv
// apb_slave_regbank_if -- APB bus bundle between a master and the register bank.
//   master modport : drives psel, penable, pwrite, paddr, pwdata (pstrb)
//                    and observes prdata, pready, pslverr
//   slave  modport : the mirror image
// APB_SLV_PSTRB_EN defined adds the pstrb byte-lane strobe.
interface apb_slave_regbank_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;
`ifdef APB_SLV_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;

  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
`else
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
`endif
endinterface

// File: rtl/apb_slave_regbank_wait_cnt.sv
// apb_slv_wait_cnt -- wait-state down-counter for the APB register bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (setup phase)
//   load_val   : number of wait cycles to insert
//   dec        : decrement by one (saturates at zero)
//   clr        : force the counter to zero (aborted transfer)
//   last       : counter currently equals 1, i.e. final wait cycle
module apb_slv_wait_cnt
  import bridge_utils::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  input  logic                  clr,
  output logic                  last
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank -- APB slave exposing DEPTH registers of DATA_WIDTH bits
// at BASE_ADDR, with WAIT_CYCLES pready-low cycles per access phase.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (clears FSM, captures, registers)
//   bus   : apb_slave_regbank_if.slave (psel, penable, pwrite, paddr,
//           pwdata, [pstrb] in; prdata, pready, pslverr out)
// Out-of-window or misaligned addresses answer with pslverr, no write, prdata=0.
// Build option: define APB_SLV_PSTRB_EN for byte-lane write strobes; a read
// with a nonzero strobe is then rejected with pslverr.
module apb_slave_regbank
  import bridge_utils::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0001_F000),
  parameter int unsigned           DEPTH       = 16,
  parameter int unsigned           WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  apb_slave_regbank_if.slave     bus
);

  localparam int unsigned NBYTES    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W     = $clog2(NBYTES);
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned WIN_BYTES = DEPTH * NBYTES;
  localparam apb_slv_state_t AFTER_SETUP = (WAIT_CYCLES > 0) ? WAIT : READY;

  apb_slv_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
`ifdef APB_SLV_PSTRB_EN
  logic [NBYTES-1:0]       pstrb_q, pstrb_d;
`endif

  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]   regs_d [DEPTH];

  logic                    cap_en;
  logic                    cnt_load;
  logic                    cnt_dec;
  logic                    cnt_clr;
  logic                    cnt_last;
  logic                    commit;
  logic                    access;
  logic                    err;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   wr_word;

  apb_slv_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .last     (cnt_last)
  );

  // Address decode works on the captured setup-phase fields, so the answer
  // is stable through any wait cycles regardless of what paddr does later.
  always_comb begin
    offset = paddr_q - BASE_ADDR;
    idx    = IDX_W'(offset >> OFF_W);
    err    = (paddr_q < BASE_ADDR)
          || (offset >= ADDR_WIDTH'(WIN_BYTES))
          || ((offset & ADDR_WIDTH'(NBYTES - 1)) != '0);
`ifdef APB_SLV_PSTRB_EN
    if (!pwrite_q && (pstrb_q != '0)) begin
      err = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cap_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // penable without a preceding setup phase is deliberately ignored
        if (bus.psel && !bus.penable) begin
          cap_en   = 1'b1;
          cnt_load = 1'b1;
          state_d  = AFTER_SETUP;
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        if (!bus.psel) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (bus.penable) begin
          commit  = pwrite_q && !err;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d  = cap_en ? bus.paddr  : paddr_q;
    pwrite_d = cap_en ? bus.pwrite : pwrite_q;
    pwdata_d = cap_en ? bus.pwdata : pwdata_q;
`ifdef APB_SLV_PSTRB_EN
    pstrb_d  = cap_en ? bus.pstrb  : pstrb_q;
`endif
  end

  // Merge of new write data into the addressed register.
  always_comb begin
`ifdef APB_SLV_PSTRB_EN
    wr_word = regs_q[idx];
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (pstrb_q[b]) begin
        wr_word[b*8 +: 8] = pwdata_q[b*8 +: 8];
      end
    end
`else
    wr_word = pwdata_q;
`endif
    regs_d = regs_q;
    if (commit) begin
      regs_d[idx] = wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
`ifdef APB_SLV_PSTRB_EN
      pstrb_q  <= '0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
`ifdef APB_SLV_PSTRB_EN
      pstrb_q  <= pstrb_d;
`endif
      regs_q   <= regs_d;
    end
  end

  // All outputs are qualified by the live access phase in READY, so an
  // async reset (state forced to IDLE) zeroes them immediately.
  assign access      = (state_q == READY) && bus.psel && bus.penable;
  assign bus.pready  = access;
  assign bus.pslverr = access && err;
  assign bus.prdata  = (access && !pwrite_q && !err) ? regs_q[idx] : '0;

endmodule

// File: doc/apb_slave_regbank.md
APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning APB data width, a multiple of 8.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0001_F000, meaning the first byte address of the register window.
REQ-004 The block SHALL have parameter DEPTH, default 16, meaning the number of DATA_WIDTH registers (power of 2).
REQ-005 The block SHALL have parameter WAIT_CYCLES, default 0, range 0..15, meaning pready-low cycles inserted per access phase.
REQ-006 The block SHALL have port clk, input, 1, system clock.
REQ-007 The block SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-008 The block SHALL have port psel, input, 1, slave select from the APB master.
REQ-009 The block SHALL have port penable, input, 1, access-phase indicator.
REQ-010 The block SHALL have port pwrite, input, 1, 1=write, 0=read.
REQ-011 The block SHALL have port paddr, input, ADDR_WIDTH, byte address.
REQ-012 The block SHALL have port pwdata, input, DATA_WIDTH, write data.
REQ-013 The block SHALL have port prdata, output, DATA_WIDTH, read data.
REQ-014 The block SHALL have port pready, output, 1, transfer completion.
REQ-015 The block SHALL have port pslverr, output, 1, transfer error, valid only with pready.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, READY.
REQ-017 IDLE: on psel=1 and penable=0, the block SHALL register paddr, pwrite, pwdata and load the wait counter with WAIT_CYCLES; next state is WAIT if WAIT_CYCLES>0, else READY.
REQ-018 WAIT: the block SHALL hold pready=0 and decrement the counter each cycle; next state is READY when the counter equals 1.
REQ-019 READY with psel=1 and penable=1: pready SHALL be 1 for exactly one cycle, then the FSM returns to IDLE. A zero-wait transfer therefore completes in 2 cycles (setup plus access); N waits take 2+N cycles.
REQ-020 Back-to-back transfers (psel held high, penable dropped after READY) SHALL be accepted with no idle cycle lost.
REQ-021 Register index SHALL be (addr - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to log2(DEPTH) bits.
REQ-022 Error: an address outside [BASE_ADDR, BASE_ADDR + DEPTH*DATA_WIDTH/8 - 1], or an address with nonzero byte-offset bits, SHALL give pslverr=1 in the READY cycle, suppress the write, and drive prdata=0.
REQ-023 A write SHALL commit at the clock edge ending the READY cycle; a read SHALL drive prdata combinationally from the indexed register during READY. At all other times prdata SHALL be 0.
REQ-024 pready, pslverr and prdata SHALL be 0 whenever the state is not READY.
REQ-025 If psel drops during WAIT or READY, the block SHALL abort to IDLE with no register write.
REQ-026 penable=1 seen in IDLE without a preceding setup phase SHALL be ignored: the block stays in IDLE with pready=0.

Reset
REQ-027 On rst_n low, even mid-transfer, the block SHALL enter IDLE, clear the counter and captured fields, set all registers to 0, and drive pready=0, pslverr=0, prdata=0.
REQ-028 A transfer interrupted by reset SHALL be dropped; any write to a register SHALL NOT occur.

Configuration
REQ-029 Macro APB_SLV_PSTRB_EN defined: the block SHALL add input pstrb, width DATA_WIDTH/8, registered at setup; a write SHALL update only byte lanes with pstrb=1; a read with pstrb nonzero SHALL give pslverr=1.
REQ-030 Macro APB_SLV_PSTRB_EN undefined: the pstrb port SHALL be absent and every write SHALL update the full word.

Structure
REQ-031 The enum apb_slv_state_t (IDLE, WAIT, READY) SHALL live in shared package bridge_utils.
REQ-032 The wait-state counter (load, decrement, last-flag) SHALL be sub-module apb_slv_wait_cnt; the register array and decode SHALL stay in the top module.

Verification
REQ-033 WAIT_CYCLES=0: write 0xDEADBEEF to 0x0001_F004, then read 0x0001_F004 -> prdata=0xDEADBEEF, pready high in cycle 2 of each transfer, pslverr=0.
REQ-034 WAIT_CYCLES=3: read 0x0001_F000 after reset -> pready low 3 access cycles then high 1 cycle; prdata=0x0, total 5 cycles.
REQ-035 Write to 0x0001_F040 (out of range) and 0x0001_F002 (unaligned) -> pslverr=1 with pready; all registers unchanged.
REQ-036 Back-to-back writes 0x11 to 0x0001_F008 and 0x22 to 0x0001_F00C, psel held -> both stored, 4 cycles total at WAIT_CYCLES=0.
REQ-037 WAIT_CYCLES=5: assert rst_n low during WAIT of a write of 0x55 to 0x0001_F000 -> outputs 0 immediately; a later read returns 0x0.
REQ-038 APB_SLV_PSTRB_EN: write 0xAABBCCDD with pstrb=4'b0101 over 0x0 -> read 0x00BB00DD; read with pstrb=4'b0001 -> pslverr=1.
